axi_uart: RTL

AXI4-Lite slave UART peripheral attached to one free slave port (s2) of the 2-master/16-slave AXI4-Lite interconnect, reachable by both the core and the JTAG debug master. Provides an 8N1 transmitter with a small TX FIFO, an 8N1 receiver with a one-byte holding register, a programmable baud divider and a level interrupt. It uses the interconnect's trimmed slave channel set: AW, W, AR and R only, with no B channel and no resp signals.

---
 rtl/axi_uart.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_uart.sv
`default_nettype none
// ============================================================================
// Module      : axi_uart
// Description : AXI4-Lite slave UART (AW/W/AR/R only, no B channel).
//               8N1 transmitter with small TX FIFO, 8N1 receiver with a
//               one-byte holding register, programmable baud divider and a
//               level receive interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_uart #(
    parameter int          TX_DEPTH = 4,
    parameter logic [15:0] BAUD_RST = 16'd433,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] uart_axi_awaddr,
    input  logic              uart_axi_awvalid,
    output logic              uart_axi_awready,
    input  logic [DATA_W-1:0] uart_axi_wdata,
    input  logic [3:0]        uart_axi_wstrb,
    input  logic              uart_axi_wvalid,
    output logic              uart_axi_wready,
    input  logic [ADDR_W-1:0] uart_axi_araddr,
    input  logic              uart_axi_arvalid,
    output logic              uart_axi_arready,
    output logic [DATA_W-1:0] uart_axi_rdata,
    output logic              uart_axi_rvalid,
    input  logic              uart_axi_rready,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              irq_o
);

    localparam int PTR_W = $clog2(TX_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_RESP = 2'd1;
    localparam logic [1:0] S_WR_ACK  = 2'd2;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_BAUD   = 3'd2;
    localparam logic [2:0] A_TXDATA = 3'd3;
    localparam logic [2:0] A_RXDATA = 3'd4;

    logic [1:0]        state, state_nxt;
    logic [2:0]        ctrl;
    logic [15:0]       baud;
    logic [16:0]       baud_p1;
    logic [15:0]       half_bit;
    logic [2:0]        wr_addr, rd_addr;
    logic              wr_fire, ar_fire;
    logic [DATA_W-1:0] rd_mux;
    logic [4:0]        status;

    // TX FIFO and shifter
    logic [7:0]        fifo_mem [TX_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_full, fifo_empty;
    logic              push_req, push, pop;
    logic              tx_busy;
    logic [8:0]        tx_sh;
    logic [3:0]        tx_bits;
    logic [15:0]       tx_cnt;

    // RX synchronizer and sequencer
    logic              rx_s1, rx_s2, rx_s3;
    logic              rx_fall;
    logic              rx_busy;
    logic [3:0]        rx_bit;
    logic [15:0]       rx_cnt;
    logic [7:0]        rx_sh;
    logic [7:0]        rx_data;
    logic              rx_valid, rx_overrun;
    logic              rd_pop, ovr_clr;

    logic              unused_bits;
    assign unused_bits = ^{uart_axi_awaddr[ADDR_W-1:5], uart_axi_awaddr[1:0],
                           uart_axi_araddr[ADDR_W-1:5], uart_axi_araddr[1:0],
                           uart_axi_wdata[DATA_W-1:16], uart_axi_wstrb[3:1]};

    assign wr_addr  = uart_axi_awaddr[4:2];
    assign rd_addr  = uart_axi_araddr[4:2];
    assign wr_fire  = (state == S_WR_ACK);
    assign ar_fire  = uart_axi_arready & uart_axi_arvalid;
    assign rd_pop   = ar_fire & (rd_addr == A_RXDATA);
    assign ovr_clr  = ar_fire & (rd_addr == A_STATUS);
    assign baud_p1  = {1'b0, baud} + 17'd1;
    assign half_bit = baud_p1[16:1];
    assign irq_o    = rx_valid & ctrl[2];

    // Bus FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Bus FSM next state: write wins over a simultaneous read request
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (uart_axi_awvalid && uart_axi_wvalid) state_nxt = S_WR_ACK;
                else if (uart_axi_arvalid)               state_nxt = S_RD_RESP;
            end
            S_WR_ACK:  state_nxt = S_IDLE;
            S_RD_RESP: if (uart_axi_rvalid && uart_axi_rready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Bus FSM outputs: arready only in the first RD_RESP cycle (before rvalid)
    always_comb begin
        uart_axi_awready = (state == S_WR_ACK);
        uart_axi_wready  = (state == S_WR_ACK);
        uart_axi_arready = (state == S_RD_RESP) && !uart_axi_rvalid;
    end

    assign status = {tx_busy, rx_overrun, rx_valid, fifo_empty, fifo_full};

    // Read data mux; unmapped and write-only locations return zero
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            A_CTRL:   rd_mux[2:0]  = ctrl;
            A_STATUS: rd_mux[4:0]  = status;
            A_BAUD:   rd_mux[15:0] = baud;
            A_RXDATA: rd_mux[7:0]  = rx_data;
            default:  rd_mux       = '0;
        endcase
    end

    // Read response: latch data on AR handshake, hold until rready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_axi_rvalid <= 1'b0;
            uart_axi_rdata  <= '0;
        end else if (ar_fire) begin
            uart_axi_rvalid <= 1'b1;
            uart_axi_rdata  <= rd_mux;
        end else if (uart_axi_rvalid && uart_axi_rready) begin
            uart_axi_rvalid <= 1'b0;
        end
    end

    // Control and baud registers, written in the WR_ACK cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= 3'd0;
            baud <= BAUD_RST;
        end else if (wr_fire && uart_axi_wstrb[0]) begin
            if (wr_addr == A_CTRL) ctrl <= uart_axi_wdata[2:0];
            if (wr_addr == A_BAUD) baud <= uart_axi_wdata[15:0];
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = ctrl[0] & ~fifo_empty & ~tx_busy;
    assign push_req   = wr_fire & uart_axi_wstrb[0] & (wr_addr == A_TXDATA);
    // A push while full is dropped unless a pop frees the slot in the same cycle
    assign push       = push_req & (~fifo_full | pop);

    // TX FIFO storage and pointers (extra wrap bit separates full from empty)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < TX_DEPTH; i++) fifo_mem[i] <= 8'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= uart_axi_wdata[7:0];
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // TX shifter: start bit driven on load, then 8 data bits and stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= 9'd0;
            tx_bits <= 4'd0;
            tx_cnt  <= 16'd0;
        end else if (pop) begin
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
            tx_sh   <= {1'b1, fifo_mem[rd_ptr[PTR_W-1:0]]};
            tx_bits <= 4'd9;
            tx_cnt  <= baud;
        end else if (tx_busy) begin
            if (tx_cnt != 16'd0) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else if (tx_bits == 4'd0) begin
                tx_busy <= 1'b0;
            end else begin
                uart_tx <= tx_sh[0];
                tx_sh   <= {1'b0, tx_sh[8:1]};
                tx_bits <= tx_bits - 4'd1;
                tx_cnt  <= baud;
            end
        end
    end

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 & ~rx_s2;

    // RX sequencer: mid-bit sampling, false-start and framing-error rejection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy    <= 1'b0;
            rx_bit     <= 4'd0;
            rx_cnt     <= 16'd0;
            rx_sh      <= 8'd0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rd_pop)  rx_valid   <= 1'b0;
            if (ovr_clr) rx_overrun <= 1'b0;
            if (!ctrl[1]) begin
                rx_busy <= 1'b0;
            end else if (!rx_busy) begin
                if (rx_fall) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= 4'd0;
                    rx_cnt  <= half_bit;
                end
            end else if (rx_cnt != 16'd0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= baud;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_busy <= 1'b0;
                    else       rx_bit  <= 4'd1;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_s2) begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        if (rx_valid && !rd_pop) rx_overrun <= 1'b1;
                    end
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
